// File: rtl/i2c_read_rdata.sv
// Bit-banged I2C register read: START, addr+W, reg pointer, RSTART, addr+R, 1..2 data bytes, STOP.
// I2C_RD_NACK_ABORT_EN: a NACK on a written byte jumps straight to STOP and leaves REG_DATA untouched.
module i2c_read_rdata (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        GO,
  input  logic [7:0]  SLAVE_ADDRESS,
  input  logic [7:0]  REG_ADDR,
  input  logic [1:0]  BYTE_NUM,
  input  logic        SDAI,
  output logic        SDAO,
  output logic        SCLO,
  output logic        END_OK,
  output logic [15:0] REG_DATA,
  output logic        NACK,
  output logic [7:0]  ST,
  output logic [3:0]  CNT
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ARM     = 4'd1,
    LAUNCH  = 4'd2,
    START_A = 4'd3,
    START_B = 4'd4,
    WBYTE   = 4'd5,
    RSTART  = 4'd6,
    RBYTE   = 4'd7,
    STOP    = 4'd8,
    DONE    = 4'd9
  } state_t;

  state_t      state, state_d;
  logic [1:0]  phase, phase_d;
  logic [3:0]  cnt, cnt_d;
  logic [7:0]  sh, sh_d;
  logic [7:0]  rsh, rsh_d;
  logic [7:0]  reg_l, reg_l_d;
  logic [7:0]  byte0, byte0_d;
  logic [7:0]  byte1, byte1_d;
  logic [6:0]  addr_l, addr_l_d;
  logic [1:0]  wsel, wsel_d;
  logic        two, two_d;
  logic        ridx, ridx_d;
  logic        sdao_d, sclo_d, end_ok_d, nack_d;
  logic [15:0] reg_data_d;
  logic        last;
  logic        abort_now;
  logic        unused_bits;

  // R/W bit is forced internally; BYTE_NUM only matters through bit 1 (0,1 -> one byte; 2,3 -> two).
  assign unused_bits = ^{SLAVE_ADDRESS[0], BYTE_NUM[0]};

`ifdef I2C_RD_NACK_ABORT_EN
  assign abort_now = NACK;
`else
  assign abort_now = 1'b0;
`endif

  assign last = ~two | ridx;
  assign ST   = {4'h0, state};
  assign CNT  = cnt;

  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state    <= IDLE;
      phase    <= 2'd0;
      cnt      <= 4'd0;
      sh       <= 8'h00;
      rsh      <= 8'h00;
      reg_l    <= 8'h00;
      byte0    <= 8'h00;
      byte1    <= 8'h00;
      addr_l   <= 7'h00;
      wsel     <= 2'd0;
      two      <= 1'b0;
      ridx     <= 1'b0;
      SDAO     <= 1'b1;
      SCLO     <= 1'b1;
      END_OK   <= 1'b1;
      NACK     <= 1'b0;
      REG_DATA <= 16'h0000;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      cnt      <= cnt_d;
      sh       <= sh_d;
      rsh      <= rsh_d;
      reg_l    <= reg_l_d;
      byte0    <= byte0_d;
      byte1    <= byte1_d;
      addr_l   <= addr_l_d;
      wsel     <= wsel_d;
      two      <= two_d;
      ridx     <= ridx_d;
      SDAO     <= sdao_d;
      SCLO     <= sclo_d;
      END_OK   <= end_ok_d;
      NACK     <= nack_d;
      REG_DATA <= reg_data_d;
    end
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    cnt_d      = cnt;
    sh_d       = sh;
    rsh_d      = rsh;
    reg_l_d    = reg_l;
    byte0_d    = byte0;
    byte1_d    = byte1;
    addr_l_d   = addr_l;
    wsel_d     = wsel;
    two_d      = two;
    ridx_d     = ridx;
    sdao_d     = SDAO;
    sclo_d     = SCLO;
    end_ok_d   = END_OK;
    nack_d     = NACK;
    reg_data_d = REG_DATA;

    case (state)
      IDLE: begin
        sdao_d   = 1'b1;
        sclo_d   = 1'b1;
        end_ok_d = 1'b1;
        if (GO) state_d = ARM;
      end
      ARM: begin
        if (!GO) state_d = LAUNCH;
      end
      LAUNCH: begin
        end_ok_d = 1'b0;
        nack_d   = 1'b0;
        cnt_d    = 4'd0;
        phase_d  = 2'd0;
        addr_l_d = SLAVE_ADDRESS[7:1];
        reg_l_d  = REG_ADDR;
        two_d    = BYTE_NUM[1];
        sh_d     = {SLAVE_ADDRESS[7:1], 1'b0};
        wsel_d   = 2'd0;
        ridx_d   = 1'b0;
        state_d  = START_A;
      end
      START_A: begin
        sdao_d  = 1'b0;
        sclo_d  = 1'b1;
        state_d = START_B;
      end
      START_B: begin
        sclo_d  = 1'b0;
        state_d = WBYTE;
      end
      WBYTE: begin
        phase_d = phase + 2'd1;
        case (phase)
          2'd0: begin
            sclo_d = 1'b0;
            if (cnt == 4'd8) begin
              sdao_d = 1'b1;
            end else begin
              sdao_d = sh[7];
              sh_d   = {sh[6:0], 1'b0};
            end
          end
          2'd1: sclo_d = 1'b1;
          2'd2: if (cnt == 4'd8 && SDAI) nack_d = 1'b1;
          2'd3: begin
            sclo_d = 1'b0;
            if (cnt == 4'd8) begin
              cnt_d = 4'd0;
              if (abort_now) begin
                state_d = STOP;
              end else begin
                case (wsel)
                  2'd0: begin
                    sh_d   = reg_l;
                    wsel_d = 2'd1;
                  end
                  2'd1:    state_d = RSTART;
                  default: state_d = RBYTE;
                endcase
              end
            end else begin
              cnt_d = cnt + 4'd1;
            end
          end
        endcase
      end
      RSTART: begin
        phase_d = phase + 2'd1;
        case (phase)
          2'd0: begin
            sdao_d = 1'b1;
            sclo_d = 1'b0;
          end
          2'd1: sclo_d = 1'b1;
          2'd2: sdao_d = 1'b0;
          2'd3: begin
            sclo_d  = 1'b0;
            sh_d    = {addr_l, 1'b1};
            wsel_d  = 2'd2;
            state_d = WBYTE;
          end
        endcase
      end
      RBYTE: begin
        phase_d = phase + 2'd1;
        case (phase)
          2'd0: begin
            sclo_d = 1'b0;
            // Master ACK (0) keeps the slave talking; NACK (1) on the final byte.
            sdao_d = (cnt == 4'd8) ? last : 1'b1;
          end
          2'd1: sclo_d = 1'b1;
          2'd2: if (cnt != 4'd8) rsh_d = {rsh[6:0], SDAI};
          2'd3: begin
            sclo_d = 1'b0;
            if (cnt == 4'd8) begin
              cnt_d = 4'd0;
              if (ridx) byte1_d = rsh;
              else      byte0_d = rsh;
              if (last) state_d = STOP;
              else      ridx_d  = 1'b1;
            end else begin
              cnt_d = cnt + 4'd1;
            end
          end
        endcase
      end
      STOP: begin
        phase_d = phase + 2'd1;
        case (phase)
          2'd0: begin
            sdao_d = 1'b0;
            sclo_d = 1'b0;
          end
          2'd1: sclo_d = 1'b1;
          default: begin
            sdao_d  = 1'b1;
            phase_d = 2'd0;
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        end_ok_d = 1'b1;
        if (!abort_now) reg_data_d = two ? {byte0, byte1} : {8'h00, byte0};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
